// File: rtl/dmem_responder.sv
// Data-memory responder for the pipeline CPU MEM stage: byte-addressable RAM with
// sub-word load/store plus an MMIO page (LED, cycle counter, compare timer, error log).
module dmem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_F000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_w,
  input  logic [31:0] Addr_in,
  input  logic [31:0] WD_in,
  input  logic [2:0]  DMType_in,
  output logic [31:0] RD_out,
  output logic [15:0] led_out,
  output logic        timer_irq,
  output logic        err_flag
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [31:0] RAM_BYTES = 32'(DEPTH_WORDS * 4);

  localparam logic [2:0] DT_HALF  = 3'b001;
  localparam logic [2:0] DT_HALFU = 3'b010;
  localparam logic [2:0] DT_BYTE  = 3'b011;
  localparam logic [2:0] DT_BYTEU = 3'b100;

  localparam logic [2:0] REG_LED   = 3'd0;
  localparam logic [2:0] REG_CYCLE = 3'd1;
  localparam logic [2:0] REG_TCMP  = 3'd2;
  localparam logic [2:0] REG_TSTAT = 3'd3;
  localparam logic [2:0] REG_ESTAT = 3'd4;
  localparam logic [2:0] REG_EADDR = 3'd5;

  logic [31:0] ram [DEPTH_WORDS];

  logic          is_byte, is_half, is_word, sign_ext, misaligned;
  logic          ram_hit, mmio_hit;
  logic [31:0]   mmio_off;
  logic [2:0]    reg_sel;
  logic [AW-1:0] ram_idx;
  logic          wr_mis, wr_unm, ram_we, mmio_we;
  logic [31:0]   wr_data;
  logic [3:0]    wr_be;
  logic [31:0]   mmio_rd, rd_word;
  logic [7:0]    rd_byte;
  logic [15:0]   rd_half;

  logic [15:0] led_q, led_d;
  logic [31:0] cycle_q, cycle_d;
  logic [31:0] tcmp_q, tcmp_d;
  logic        expired_q, expired_d;
  logic        irq_en_q, irq_en_d;
  logic [1:0]  estat_q, estat_d;
  logic [31:0] eaddr_q, eaddr_d;

  always_comb begin
    is_byte    = (DMType_in == DT_BYTE) || (DMType_in == DT_BYTEU);
    is_half    = (DMType_in == DT_HALF) || (DMType_in == DT_HALFU);
    is_word    = !is_byte && !is_half;
    sign_ext   = (DMType_in == DT_BYTE) || (DMType_in == DT_HALF);
    misaligned = (is_half && Addr_in[0]) || (is_word && (Addr_in[1:0] != 2'b00));
  end

  always_comb begin
    ram_hit  = Addr_in < RAM_BYTES;
    mmio_off = Addr_in - MMIO_BASE;
    mmio_hit = !ram_hit && (mmio_off < 32'h18);
    reg_sel  = mmio_off[4:2];
    ram_idx  = Addr_in[AW+1:2];
  end

  // MMIO only accepts aligned word stores; misaligned wins over unmapped.
  always_comb begin
    wr_mis  = mem_w && (misaligned || (mmio_hit && !is_word));
    wr_unm  = mem_w && !wr_mis && !ram_hit && !mmio_hit;
    ram_we  = mem_w && ram_hit && !misaligned;
    mmio_we = mem_w && mmio_hit && is_word && !misaligned;
  end

  always_comb begin
    wr_data = WD_in;
    wr_be   = 4'hF;
    if (is_byte) begin
      wr_data = {4{WD_in[7:0]}};
      wr_be   = 4'b0001 << Addr_in[1:0];
    end else if (is_half) begin
      wr_data = {2{WD_in[15:0]}};
      wr_be   = Addr_in[1] ? 4'b1100 : 4'b0011;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) ram[ram_idx][8*i +: 8] <= wr_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    mmio_rd = '0;
    case (reg_sel)
      REG_LED:   mmio_rd = {16'h0, led_q};
      REG_CYCLE: mmio_rd = cycle_q;
      REG_TCMP:  mmio_rd = tcmp_q;
      REG_TSTAT: mmio_rd = {30'h0, irq_en_q, expired_q};
      REG_ESTAT: mmio_rd = {30'h0, estat_q};
      REG_EADDR: mmio_rd = eaddr_q;
      default:   mmio_rd = '0;
    endcase
  end

  always_comb begin
    rd_word = '0;
    if (ram_hit)       rd_word = ram[ram_idx];
    else if (mmio_hit) rd_word = mmio_rd;
    rd_byte = rd_word[{Addr_in[1:0], 3'b000} +: 8];
    rd_half = Addr_in[1] ? rd_word[31:16] : rd_word[15:0];
    RD_out  = rd_word;
    if (misaligned)   RD_out = '0;
    else if (is_byte) RD_out = sign_ext ? {{24{rd_byte[7]}}, rd_byte} : {24'h0, rd_byte};
    else if (is_half) RD_out = sign_ext ? {{16{rd_half[15]}}, rd_half} : {16'h0, rd_half};
  end

  // Set conditions are applied after the W1C clears so they win on collision.
  always_comb begin
    led_d     = led_q;
    cycle_d   = cycle_q + 32'd1;
    tcmp_d    = tcmp_q;
    expired_d = expired_q;
    irq_en_d  = irq_en_q;
    estat_d   = estat_q;
    eaddr_d   = eaddr_q;
    if (mmio_we) begin
      case (reg_sel)
        REG_LED:   led_d = WD_in[15:0];
        REG_TCMP:  tcmp_d = WD_in;
        REG_TSTAT: begin
          irq_en_d = WD_in[1];
          if (WD_in[0]) expired_d = 1'b0;
        end
        REG_ESTAT: estat_d = estat_q & ~WD_in[1:0];
        default: ;
      endcase
    end
    if (cycle_q == tcmp_q) expired_d = 1'b1;
    if (wr_mis) begin
      estat_d[0] = 1'b1;
      eaddr_d    = Addr_in;
    end else if (wr_unm) begin
      estat_d[1] = 1'b1;
      eaddr_d    = Addr_in;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      led_q     <= '0;
      cycle_q   <= '0;
      tcmp_q    <= 32'hFFFF_FFFF;
      expired_q <= 1'b0;
      irq_en_q  <= 1'b0;
      estat_q   <= '0;
      eaddr_q   <= '0;
    end else begin
      led_q     <= led_d;
      cycle_q   <= cycle_d;
      tcmp_q    <= tcmp_d;
      expired_q <= expired_d;
      irq_en_q  <= irq_en_d;
      estat_q   <= estat_d;
      eaddr_q   <= eaddr_d;
    end
  end

  assign led_out   = led_q;
  assign timer_irq = expired_q && irq_en_q;
  assign err_flag  = |estat_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: directed loads/stores and MMIO accesses push
// expected values; a negedge monitor pops and compares against the selected output.
module tb_dmem_responder;

  localparam logic [31:0] MMIO  = 32'hFFFF_F000;
  localparam logic [31:0] LED   = MMIO + 32'h00;
  localparam logic [31:0] CYC   = MMIO + 32'h04;
  localparam logic [31:0] TCMP  = MMIO + 32'h08;
  localparam logic [31:0] TSTAT = MMIO + 32'h0C;
  localparam logic [31:0] ESTAT = MMIO + 32'h10;
  localparam logic [31:0] EADDR = MMIO + 32'h14;

  localparam logic [2:0] W = 3'b000, H = 3'b001, HU = 3'b010, B = 3'b011, BU = 3'b100;
  localparam int K_RD = 0, K_LED = 1, K_IRQ = 2, K_ERR = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_w = 1'b0;
  logic [31:0] Addr_in = '0;
  logic [31:0] WD_in = '0;
  logic [2:0]  DMType_in = W;
  logic [31:0] RD_out;
  logic [15:0] led_out;
  logic        timer_irq;
  logic        err_flag;

  logic        chk_valid = 1'b0;
  logic [31:0] tb_cycle;
  int          vectors = 0;
  int          miscompares = 0;

  logic [31:0] exp_q[$];
  int          kind_q[$];
  string       name_q[$];

  dmem_responder #(.DEPTH_WORDS(1024), .MMIO_BASE(MMIO)) dut (
    .clk(clk), .rst(rst), .mem_w(mem_w), .Addr_in(Addr_in), .WD_in(WD_in),
    .DMType_in(DMType_in), .RD_out(RD_out), .led_out(led_out),
    .timer_irq(timer_irq), .err_flag(err_flag)
  );

  always #5 clk = ~clk;

  // Reference model of the free-running cycle counter.
  always @(posedge clk or negedge rst) begin
    if (!rst) tb_cycle <= '0;
    else      tb_cycle <= tb_cycle + 32'd1;
  end

  always @(negedge clk) begin
    logic [31:0] e, act;
    int          k;
    string       n;
    if (chk_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("[TB] FAIL scoreboard_empty: no expected value queued");
      end else begin
        e = exp_q.pop_front();
        k = kind_q.pop_front();
        n = name_q.pop_front();
        case (k)
          K_LED:   act = {16'h0, led_out};
          K_IRQ:   act = {31'h0, timer_irq};
          K_ERR:   act = {31'h0, err_flag};
          default: act = RD_out;
        endcase
        if (act !== e) begin
          miscompares++;
          $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", n, act, e);
        end
      end
    end
  end

  task automatic apply_stimulus(input logic [31:0] addr, input logic [31:0] data,
                                input logic [2:0] dtype);
    mem_w = 1'b1;
    Addr_in = addr;
    WD_in = data;
    DMType_in = dtype;
    @(posedge clk);
    #1;
    mem_w = 1'b0;
  endtask

  task automatic check_output(input int kind, input logic [31:0] addr, input logic [2:0] dtype,
                              input logic [31:0] exp, input string name);
    mem_w = 1'b0;
    Addr_in = addr;
    DMType_in = dtype;
    exp_q.push_back(exp);
    kind_q.push_back(kind);
    name_q.push_back(name);
    chk_valid = 1'b1;
    @(posedge clk);
    #1;
    chk_valid = 1'b0;
  endtask

  task automatic check_read(input logic [31:0] addr, input logic [2:0] dtype,
                            input logic [31:0] exp, input string name);
    check_output(K_RD, addr, dtype, exp, name);
  endtask

  task automatic check_pin(input int kind, input logic [31:0] exp, input string name);
    check_output(kind, 32'h0, W, exp, name);
  endtask

  task automatic idle_until(input logic [31:0] target);
    int guard = 0;
    while (tb_cycle < target) begin
      if (guard > 300) begin
        miscompares++;
        $display("[TB] FAIL idle_timeout: cycle 0x%08h target 0x%08h", tb_cycle, target);
        return;
      end
      guard++;
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    logic [31:0] target;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_read(CYC, W, 32'd1, "cycle_after_reset");
    check_read(LED, W, 32'h0, "led_reg_reset");
    check_pin(K_LED, 32'h0, "led_out_reset");
    check_read(TCMP, W, 32'hFFFF_FFFF, "tcmp_reset");
    check_read(TSTAT, W, 32'h0, "tstat_reset");
    check_read(ESTAT, W, 32'h0, "estat_reset");
    check_read(EADDR, W, 32'h0, "eaddr_reset");
    check_pin(K_ERR, 32'h0, "err_reset");
    check_pin(K_IRQ, 32'h0, "irq_reset");

    apply_stimulus(TCMP, 32'd20, W);
    apply_stimulus(TSTAT, 32'h2, W);
    idle_until(32'd20);
    check_pin(K_IRQ, 32'h0, "irq_at_match_cycle");
    check_pin(K_IRQ, 32'h1, "irq_after_match");
    check_read(TSTAT, W, 32'h3, "tstat_expired");
    apply_stimulus(TSTAT, 32'h3, W);
    check_pin(K_IRQ, 32'h0, "irq_after_w1c");
    check_read(TSTAT, W, 32'h2, "tstat_after_w1c");

    target = tb_cycle + 32'd4;
    apply_stimulus(TCMP, target, W);
    idle_until(target);
    apply_stimulus(TSTAT, 32'h3, W);
    check_read(TSTAT, W, 32'h3, "set_beats_w1c");
    apply_stimulus(TSTAT, 32'h3, W);
    apply_stimulus(TCMP, tb_cycle, W);
    check_read(TSTAT, W, 32'h2, "tcmp_write_uses_old");

    apply_stimulus(32'h10, 32'h8081_F2F3, W);
    check_read(32'h10, W,  32'h8081_F2F3, "word_0x10");
    check_read(32'h10, B,  32'hFFFF_FFF3, "byte_0x10");
    check_read(32'h13, BU, 32'h0000_0080, "byteu_0x13");
    check_read(32'h12, H,  32'hFFFF_8081, "half_0x12");
    check_read(32'h10, HU, 32'h0000_F2F3, "halfu_0x10");
    check_read(32'h11, H,  32'h0, "misaligned_half_read");
    check_read(32'h12, W,  32'h0, "misaligned_word_read");

    apply_stimulus(32'h20, 32'h1122_3344, W);
    apply_stimulus(32'h21, 32'h0000_00AA, B);
    check_read(32'h20, W, 32'h1122_AA44, "byte_store_merge");
    apply_stimulus(32'h22, 32'h0000_BEEF, H);
    check_read(32'h20, W, 32'hBEEF_AA44, "half_store_merge");

    apply_stimulus(32'hFFC, 32'h5A5A_1234, W);
    check_read(32'hFFC, W, 32'h5A5A_1234, "last_ram_word");
    check_read(32'hFFF, B, 32'h0000_005A, "last_ram_byte");
    check_read(32'h1000, W, 32'h0, "unmapped_read");

    apply_stimulus(CYC, 32'h0, W);
    check_read(CYC, W, tb_cycle, "cycle_write_ignored");
    check_read(ESTAT, W, 32'h0, "cycle_write_no_error");

    apply_stimulus(32'h04, 32'hCAFE_F00D, W);
    apply_stimulus(32'h06, 32'hDEAD_BEEF, W);
    apply_stimulus(32'hFFFF_0000, 32'h1234_5678, W);
    check_read(32'h04, W, 32'hCAFE_F00D, "ram_unchanged_after_misaligned");
    check_read(ESTAT, W, 32'h3, "estat_both");
    check_read(EADDR, W, 32'hFFFF_0000, "eaddr_unmapped");
    check_pin(K_ERR, 32'h1, "err_flag_set");
    apply_stimulus(ESTAT, 32'h1, W);
    check_read(ESTAT, W, 32'h2, "estat_w1c_bit0");
    apply_stimulus(ESTAT, 32'h3, W);
    check_pin(K_ERR, 32'h0, "err_flag_cleared");

    apply_stimulus(LED, 32'h1234_5678, W);
    check_pin(K_LED, 32'h5678, "led_out_write");
    check_read(LED, W, 32'h0000_5678, "led_reg_read");
    apply_stimulus(LED, 32'h0000_FFFF, H);
    check_pin(K_LED, 32'h5678, "led_half_suppressed");
    check_read(ESTAT, W, 32'h1, "estat_mmio_subword");
    check_read(EADDR, W, LED, "eaddr_mmio_subword");
    apply_stimulus(MMIO + 32'h18, 32'h1, W);
    check_read(ESTAT, W, 32'h3, "estat_past_mmio_regs");

    target = tb_cycle + 32'd3;
    apply_stimulus(TCMP, target, W);
    idle_until(target + 32'd1);
    check_pin(K_IRQ, 32'h1, "irq_before_reset");
    check_pin(K_ERR, 32'h1, "err_before_reset");
    idle_until(32'd100);

    rst = 1'b0;
    check_pin(K_LED, 32'h0, "led_out_in_reset");
    check_pin(K_IRQ, 32'h0, "irq_in_reset");
    check_pin(K_ERR, 32'h0, "err_in_reset");
    check_read(CYC, W, 32'h0, "cycle_in_reset");
    check_read(TCMP, W, 32'hFFFF_FFFF, "tcmp_in_reset");
    check_read(TSTAT, W, 32'h0, "tstat_in_reset");
    check_read(ESTAT, W, 32'h0, "estat_in_reset");
    check_read(EADDR, W, 32'h0, "eaddr_in_reset");
    check_read(32'h10, W, 32'h8081_F2F3, "ram_kept_in_reset");
    check_read(32'h20, W, 32'hBEEF_AA44, "ram_kept_in_reset_2");
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_read(CYC, W, 32'd1, "cycle_after_rerelease");

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("[TB] FAIL scoreboard_leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
